// File: rtl/selftrigger_pulse_qualifier.sv
// Per-channel self-trigger pulse qualifier. Each trigger becomes one pulse record
// (timestamp, peak, peak position, width, charge), followed by a post-pulse holdoff.
module selftrigger_pulse_qualifier #(
    parameter  int HOLDOFF   = 64,
    parameter  int MAX_WIDTH = 1024,
    parameter  int CHARGE_W  = 24,
    localparam int PW        = $clog2(MAX_WIDTH),
    localparam int WW        = PW + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                trigger_in,
    input  logic [15:0]         x,
    input  logic [15:0]         baseline,
    input  logic [63:0]         timestamp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_ts,
    output logic [15:0]         out_peak,
    output logic [PW-1:0]       out_peak_pos,
    output logic [WW-1:0]       out_width,
    output logic [CHARGE_W-1:0] out_charge,
    output logic                out_truncated,
    output logic [15:0]         drop_count,
    output logic [15:0]         suppressed_count
);
    localparam int HW  = $clog2(HOLDOFF + 2);
    localparam int CW1 = CHARGE_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EMIT, S_HOLD} state_t;

    typedef struct packed {
        logic [63:0]         ts;
        logic [15:0]         peak;
        logic [PW-1:0]       pos;
        logic [WW-1:0]       width;
        logic [CHARGE_W-1:0] charge;
        logic                trunc;
    } rec_t;

    state_t        state_q, state_d;
    rec_t          acc_q, acc_d, out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]   drop_q, drop_d, supp_q, supp_d;
    logic          trig_prev_q;

    logic                rise, at_last;
    logic signed [16:0]  diff;
    logic signed [15:0]  amp;
    logic signed [CW1-1:0] csum;
    logic [CHARGE_W-1:0] charge_sat;

    assign rise    = trigger_in & ~trig_prev_q;
    assign at_last = acc_q.width >= WW'(MAX_WIDTH - 1);

    always_comb begin
        diff = {x[15], x} - {baseline[15], baseline};
        amp  = diff[15:0];
        if (diff[16] != diff[15]) amp = diff[16] ? 16'sh8000 : 16'sh7fff;
        csum       = CW1'($signed(acc_q.charge)) + CW1'(amp);
        charge_sat = csum[CHARGE_W-1:0];
        if (csum[CHARGE_W] != csum[CHARGE_W-1])
            charge_sat = {csum[CHARGE_W], {(CHARGE_W-1){~csum[CHARGE_W]}}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            drop_q      <= '0;
            supp_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            drop_q      <= drop_d;
            supp_q      <= supp_d;
            trig_prev_q <= trigger_in;
        end
    end

    // Disable wins from every state, so a record not yet in the output register is lost too.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (rise) state_d = S_ACTIVE;
            S_ACTIVE: if (!trigger_in || at_last) state_d = S_EMIT;
            S_EMIT:   state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            S_HOLD:   if (hold_cnt_q <= HW'(1)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;
    end

    always_comb begin
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q & ~out_ready;
        hold_cnt_d  = hold_cnt_q;
        drop_d      = drop_q;
        supp_d      = supp_q;
        unique case (state_q)
            S_IDLE: if (enable && rise) begin
                acc_d.ts     = timestamp;
                acc_d.peak   = amp;
                acc_d.pos    = '0;
                acc_d.width  = WW'(1);
                acc_d.charge = CHARGE_W'(amp);
                acc_d.trunc  = 1'b0;
            end
            S_ACTIVE: if (trigger_in) begin
                // The MAX_WIDTH-th sample is absorbed and flagged in the same cycle.
                if (acc_q.width < WW'(MAX_WIDTH)) begin
                    acc_d.width  = acc_q.width + WW'(1);
                    acc_d.charge = charge_sat;
                    if (amp > $signed(acc_q.peak)) begin
                        acc_d.peak = amp;
                        acc_d.pos  = acc_q.width[PW-1:0];
                    end
                end
                if (at_last) acc_d.trunc = 1'b1;
            end
            S_EMIT: begin
                hold_cnt_d = HW'(HOLDOFF);
                if (enable) begin
                    if (!out_valid_q || out_ready) begin
                        out_d       = acc_q;
                        out_valid_d = 1'b1;
                    end else if (drop_q != 16'hffff) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q - HW'(1);
                if (rise && supp_q != 16'hffff) supp_d = supp_q + 16'd1;
            end
            default: ;
        endcase
    end

    assign out_valid        = out_valid_q;
    assign out_ts           = out_q.ts;
    assign out_peak         = out_q.peak;
    assign out_peak_pos     = out_q.pos;
    assign out_width        = out_q.width;
    assign out_charge       = out_q.charge;
    assign out_truncated    = out_q.trunc;
    assign drop_count       = drop_q;
    assign suppressed_count = supp_q;

endmodule

// File: tb/tb_selftrigger_pulse_qualifier.sv
// Bench for selftrigger_pulse_qualifier: directed scenarios plus random streams,
// checked against a stream-scanning reference model.
module tb_selftrigger_pulse_qualifier;
    localparam int H  = 6;
    localparam int MW = 8;
    localparam int CW = 16;
    localparam int PW = $clog2(MW);
    localparam int WW = PW + 1;
    localparam int N  = 400;

    logic          clk = 1'b0, reset_n = 1'b0, enable = 1'b0, trigger_in = 1'b0, out_ready = 1'b0;
    logic [15:0]   x = '0, baseline = '0;
    logic [63:0]   timestamp = '0;
    logic          out_valid, out_truncated;
    logic [63:0]   out_ts;
    logic [15:0]   out_peak, drop_count, suppressed_count;
    logic [PW-1:0] out_peak_pos;
    logic [WW-1:0] out_width;
    logic [CW-1:0] out_charge;

    always #5 clk = ~clk;

    selftrigger_pulse_qualifier #(.HOLDOFF(H), .MAX_WIDTH(MW), .CHARGE_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .trigger_in(trigger_in),
        .x(x), .baseline(baseline), .timestamp(timestamp),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_peak(out_peak), .out_peak_pos(out_peak_pos), .out_width(out_width),
        .out_charge(out_charge), .out_truncated(out_truncated),
        .drop_count(drop_count), .suppressed_count(suppressed_count)
    );

    typedef struct {
        longint unsigned ts;
        int peak, pos, width, charge;
        bit trunc;
    } rec_t;

    bit   trig_a[N], en_a[N], rdy_a[N], emit_a[N];
    int   x_a[N], b_a[N];
    rec_t emit_r[N];
    rec_t obs[$];
    int   m_supp, m_drop, first_valid;
    int   n_tests = 0, n_fail = 0;
    logic [63:0] ts_base;

    function automatic int amp_of(int i);
        int d = x_a[i] - b_a[i];
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return d;
    endfunction

    function automatic int csat(int v);
        int lim = 1 << (CW - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic bit rise_at(int i);
        return trig_a[i] && (i == 0 || !trig_a[i-1]);
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            trig_a[i] = 0; en_a[i] = 1; rdy_a[i] = 1; x_a[i] = 0; b_a[i] = 0;
        end
        ts_base = {$urandom, $urandom};
    endtask

    // Scan the whole stimulus for pulses: where each starts, what it contains,
    // on which cycle its record is offered, and which edges fall inside holdoff.
    task automatic build_model(int n);
        int i, j, e, s, a;
        bit aborted;
        rec_t r;
        m_supp = 0;
        for (int k = 0; k < N; k++) emit_a[k] = 0;
        i = 0;
        while (i < n) begin
            if (!(en_a[i] && rise_at(i))) begin i++; continue; end
            s = i; a = amp_of(s);
            r.ts = ts_base + 64'(s); r.peak = a; r.pos = 0; r.width = 1;
            r.charge = csat(a); r.trunc = 0;
            aborted = 0; j = s + 1;
            while (j < n) begin
                if (!en_a[j]) begin aborted = 1; break; end
                if (!trig_a[j]) break;
                a = amp_of(j);
                if (a > r.peak) begin r.peak = a; r.pos = r.width; end
                r.width++;
                r.charge = csat(r.charge + a);
                if (r.width == MW) begin r.trunc = 1; break; end
                j++;
            end
            e = j;
            if (aborted || e + 1 >= n) begin i = e + 1; continue; end
            if (!en_a[e+1]) begin i = e + 2; continue; end
            emit_a[e+1] = 1; emit_r[e+1] = r;
            i = e + 2 + H;
            for (int k = e + 2; k <= e + 1 + H && k < n; k++) begin
                if (rise_at(k)) m_supp++;
                if (!en_a[k]) begin i = k + 1; break; end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0; trigger_in = 0; enable = 0; out_ready = 0; x = '0; baseline = '0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic run_stream(int n);
        rec_t cur, got;
        bit   ov = 0;
        int   n_xfer = 0;
        build_model(n);
        do_reset();
        obs.delete(); first_valid = -1; m_drop = 0;
        cur = '{default: 0};
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            trigger_in = trig_a[c]; enable = en_a[c]; out_ready = rdy_a[c];
            x = 16'(x_a[c]); baseline = 16'(b_a[c]); timestamp = ts_base + 64'(c);
            #1;
            n_tests++;
            if (out_valid !== ov) begin
                n_fail++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", c, out_valid, ov);
            end
            if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
            got.ts = out_ts; got.peak = int'($signed(out_peak)); got.pos = int'(out_peak_pos);
            got.width = int'(out_width); got.charge = int'($signed(out_charge)); got.trunc = out_truncated;
            if (ov) begin
                n_tests++;
                if (got.ts !== cur.ts || got.peak !== cur.peak || got.pos !== cur.pos ||
                    got.width !== cur.width || got.charge !== cur.charge || got.trunc !== cur.trunc) begin
                    n_fail++;
                    $display("FAIL record cyc=%0d got ts=%0h pk=%0d pos=%0d w=%0d q=%0d tr=%0b exp ts=%0h pk=%0d pos=%0d w=%0d q=%0d tr=%0b",
                             c, got.ts, got.peak, got.pos, got.width, got.charge, got.trunc,
                             cur.ts, cur.peak, cur.pos, cur.width, cur.charge, cur.trunc);
                end
            end
            if (out_valid === 1'b1 && out_ready) obs.push_back(got);
            if (emit_a[c]) begin
                if (!ov || rdy_a[c]) begin
                    if (ov) n_xfer++;
                    cur = emit_r[c]; ov = 1;
                end else m_drop++;
            end else if (ov && rdy_a[c]) begin
                n_xfer++; ov = 0;
            end
        end
        @(negedge clk);
        trigger_in = 0; out_ready = 0;
        #1;
        n_tests++;
        if (drop_count !== 16'(m_drop) || suppressed_count !== 16'(m_supp) || obs.size() !== n_xfer) begin
            n_fail++;
            $display("FAIL counters got drop=%0d supp=%0d xfers=%0d exp drop=%0d supp=%0d xfers=%0d",
                     drop_count, suppressed_count, obs.size(), m_drop, m_supp, n_xfer);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        #1;
        n_tests++;
        if (out_valid !== 0 || drop_count !== 0 || suppressed_count !== 0 || out_ts !== 0 ||
            out_peak !== 0 || out_width !== 0 || out_charge !== 0 || out_truncated !== 0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b drop=%0d supp=%0d w=%0d exp all zero",
                     out_valid, drop_count, suppressed_count, out_width);
        end
    endtask

    task automatic test_basic();
        clear_stim();
        for (int i = 0; i < N; i++) begin b_a[i] = 100; x_a[i] = 100; end
        x_a[2] = 100; x_a[3] = 150; x_a[4] = 300; x_a[5] = 200; x_a[6] = 120;
        for (int i = 2; i <= 6; i++) trig_a[i] = 1;
        run_stream(30);
        n_tests++;
        if (obs.size() !== 1) begin
            n_fail++; $display("FAIL basic_count got=%0d exp=1", obs.size());
        end else begin
            n_tests++;
            if (obs[0].peak !== 200 || obs[0].pos !== 2 || obs[0].width !== 5 ||
                obs[0].charge !== 370 || obs[0].trunc !== 0 || obs[0].ts !== ts_base + 64'd2) begin
                n_fail++;
                $display("FAIL basic_fields got pk=%0d pos=%0d w=%0d q=%0d exp 200 2 5 370",
                         obs[0].peak, obs[0].pos, obs[0].width, obs[0].charge);
            end
        end
        n_tests++;
        if (first_valid !== 9) begin
            n_fail++; $display("FAIL basic_latency got=%0d exp=9", first_valid);
        end
    endtask

    task automatic test_equal_peaks();
        clear_stim();
        x_a[2] = 50; x_a[3] = 80; x_a[4] = 80; x_a[5] = 10;
        for (int i = 2; i <= 5; i++) trig_a[i] = 1;
        run_stream(30);
        n_tests++;
        if (obs.size() !== 1 || obs[0].peak !== 80 || obs[0].pos !== 1) begin
            n_fail++;
            $display("FAIL equal_peaks got n=%0d pk=%0d pos=%0d exp n=1 pk=80 pos=1",
                     obs.size(), obs.size() > 0 ? obs[0].peak : 0, obs.size() > 0 ? obs[0].pos : 0);
        end
    endtask

    task automatic test_truncation();
        clear_stim();
        for (int i = 0; i < N; i++) x_a[i] = 10;
        for (int i = 2; i <= 21; i++) trig_a[i] = 1;
        for (int i = 40; i <= 42; i++) trig_a[i] = 1;
        run_stream(60);
        n_tests++;
        if (obs.size() !== 2) begin
            n_fail++; $display("FAIL trunc_count got=%0d exp=2", obs.size());
        end else begin
            n_tests++;
            if (obs[0].width !== 8 || obs[0].charge !== 80 || obs[0].trunc !== 1 ||
                obs[1].width !== 3 || obs[1].trunc !== 0) begin
                n_fail++;
                $display("FAIL trunc_fields got w=%0d q=%0d tr=%0b w2=%0d exp 8 80 1 3",
                         obs[0].width, obs[0].charge, obs[0].trunc, obs[1].width);
            end
        end
        n_tests++;
        if (first_valid !== 11) begin
            n_fail++; $display("FAIL trunc_latency got=%0d exp=11", first_valid);
        end
    endtask

    task automatic test_holdoff();
        int gaps[3] = '{3, 20, 9};
        int exp_n[3] = '{1, 2, 2};
        int exp_s[3] = '{1, 0, 0};
        for (int t = 0; t < 3; t++) begin
            clear_stim();
            trig_a[2] = 1; trig_a[2 + gaps[t]] = 1;
            run_stream(50);
            n_tests++;
            if (obs.size() !== exp_n[t] || suppressed_count !== 16'(exp_s[t])) begin
                n_fail++;
                $display("FAIL holdoff gap=%0d got n=%0d supp=%0d exp n=%0d supp=%0d",
                         gaps[t], obs.size(), suppressed_count, exp_n[t], exp_s[t]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_stim();
        for (int i = 0; i < 60; i++) rdy_a[i] = 0;
        trig_a[2] = 1; trig_a[15] = 1; trig_a[28] = 1;
        run_stream(70);
        n_tests++;
        if (drop_count !== 16'd2 || obs.size() !== 1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure got drop=%0d n=%0d v=%b exp drop=2 n=1 v=0",
                     drop_count, obs.size(), out_valid);
        end else begin
            n_tests++;
            if (obs[0].ts !== ts_base + 64'd2) begin
                n_fail++; $display("FAIL bp_first_ts got=%0h exp=%0h", obs[0].ts, ts_base + 64'd2);
            end
        end
    endtask

    task automatic test_saturation();
        clear_stim();
        for (int i = 2; i <= 4; i++) begin trig_a[i] = 1; x_a[i] = 32767; b_a[i] = -32768; end
        for (int i = 20; i <= 22; i++) begin trig_a[i] = 1; x_a[i] = -32768; b_a[i] = 32767; end
        run_stream(40);
        n_tests++;
        if (obs.size() !== 2) begin
            n_fail++; $display("FAIL sat_count got=%0d exp=2", obs.size());
        end else begin
            n_tests++;
            if (obs[0].peak !== 32767 || obs[0].charge !== 32767 ||
                obs[1].peak !== -32768 || obs[1].charge !== -32768 || obs[1].pos !== 0) begin
                n_fail++;
                $display("FAIL sat_fields got pk=%0d q=%0d pk2=%0d q2=%0d exp 32767 32767 -32768 -32768",
                         obs[0].peak, obs[0].charge, obs[1].peak, obs[1].charge);
            end
        end
    endtask

    task automatic test_enable();
        clear_stim();
        for (int i = 2; i <= 8; i++) trig_a[i] = 1;
        en_a[5] = 0;
        for (int i = 20; i <= 22; i++) trig_a[i] = 1;
        for (int i = 20; i < 35; i++) rdy_a[i] = 0;
        for (int i = 30; i <= 40; i++) en_a[i] = 0;
        run_stream(60);
        n_tests++;
        if (obs.size() !== 1 || drop_count !== 0 || first_valid !== 25) begin
            n_fail++;
            $display("FAIL enable got n=%0d drop=%0d first=%0d exp n=1 drop=0 first=25",
                     obs.size(), drop_count, first_valid);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            @(negedge clk);
            enable = 1; out_ready = 0; x = 16'd500; baseline = '0; timestamp = 64'(c);
            trigger_in = (c == 2) || (c == 15) || (c >= 28);
        end
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || drop_count !== 16'd1) begin
            n_fail++; $display("FAIL pre_reset got v=%b drop=%0d exp v=1 drop=1", out_valid, drop_count);
        end
        #2 reset_n = 0;
        #1;
        n_tests++;
        if (out_valid !== 0 || drop_count !== 0 || suppressed_count !== 0 || out_width !== 0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b drop=%0d supp=%0d w=%0d exp zeros",
                     out_valid, drop_count, suppressed_count, out_width);
        end
        repeat (2) @(negedge clk);
        reset_n = 1; trigger_in = 0; out_ready = 1;
        n_tests++;
        begin
            bit seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk); #1;
                if (out_valid !== 1'b0) seen = 1;
            end
            if (seen) begin n_fail++; $display("FAIL post_reset_record got=1 exp=0"); end
        end
    endtask

    task automatic test_random();
        int c, lo, hi;
        for (int it = 0; it < 6; it++) begin
            clear_stim();
            c = 0;
            while (c < N - 20) begin
                lo = $urandom_range(1, 12);
                hi = $urandom_range(1, 12);
                c += lo;
                for (int k = 0; k < hi && c < N - 20; k++) begin trig_a[c] = 1; c++; end
            end
            for (int i = 0; i < N; i++) begin
                x_a[i] = int'($urandom_range(0, 65535)) - 32768;
                b_a[i] = (it < 3) ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 65535)) - 32768;
                if (it < 3) x_a[i] = b_a[i] + int'($urandom_range(0, 3000)) - 500;
                rdy_a[i] = ($urandom_range(0, 9) < 7);
                en_a[i]  = ($urandom_range(0, 49) != 0);
            end
            run_stream(N);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_equal_peaks();
        test_truncation();
        test_holdoff();
        test_backpressure();
        test_saturation();
        test_enable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/selftrigger_pulse_qualifier.md
Name: selftrigger_pulse_qualifier

Overview:
- Sits directly downstream of the HPF/pedestal-recovery/trigger filter stage, one instance per channel.
- Consumes the filter's trigger flag, filtered waveform and baseline, and turns each trigger into a single qualified pulse record: timestamp, peak, peak position, width and integrated charge.
- Enforces a post-pulse holdoff and hands records to the frame builder over a valid/ready handshake.

Parameters:
HOLDOFF, 64, dead-time cycles after each pulse end; triggers are ignored during it
MAX_WIDTH, 1024, maximum pulse length in samples; longer pulses are truncated
CHARGE_W, 24, width of the signed charge accumulator

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  channel enable; synchronous qualifier
trigger_in  in  1  trigger flag from the filter stage
x  in  16  signed filtered sample, aligned with trigger_in
baseline  in  16  signed baseline from the filter stage
timestamp  in  64  free-running timestamp
out_valid  out  1  record available
out_ready  in  1  consumer accepts record
out_ts  out  64  timestamp of the trigger rising-edge sample
out_peak  out  16  signed max amplitude (x - baseline)
out_peak_pos  out  clog2(MAX_WIDTH)  sample offset of the peak from pulse start
out_width  out  clog2(MAX_WIDTH)+1  samples in the pulse
out_charge  out  CHARGE_W  signed sum of amplitudes
out_truncated  out  1  pulse hit MAX_WIDTH
drop_count  out  16  records lost to backpressure; saturating
suppressed_count  out  16  rising edges ignored in holdoff; saturating

Behaviour:
- Reset (reset_n low, asynchronous): all outputs, counters and registers go to 0; FSM to IDLE.
- Amplitude: amp = x - baseline, computed at 17 bits, saturated to 16-bit signed range [-32768, 32767].
- Charge: amp sign-extended to CHARGE_W; accumulation saturates at the signed CHARGE_W limits.
- Rising edge: trigger_in=1 while the registered previous trigger_in=0. The edge register updates every cycle, including when enable=0.
- FSM states:
  - IDLE: on a rising edge with enable=1 -> ACTIVE. Capture ts=timestamp, peak=amp, peak_pos=0, width=1, charge=amp, truncated=0.
  - ACTIVE, trigger_in=1 and width<MAX_WIDTH: width+=1, charge+=amp. If amp > peak (strictly greater, so the earliest maximum is kept): peak=amp, peak_pos=old width.
  - ACTIVE, trigger_in=0: pulse ends. That sample is not included. Go to EMIT.
  - ACTIVE, width==MAX_WIDTH with trigger_in still 1: truncated=1, go to EMIT.
  - EMIT (one cycle):
    - If out_valid=0, or out_valid=1 and out_ready=1 this cycle: load the output registers and set out_valid=1.
    - Otherwise: drop_count+=1; the existing record is untouched.
    - Then -> HOLDOFF with counter=HOLDOFF.
  - HOLDOFF: decrement the counter each cycle; each rising edge seen here increments suppressed_count. At 0 -> IDLE. A trigger still high on entry to IDLE does not start a pulse; a fresh rising edge is required.
  - HOLDOFF=0: EMIT goes straight to IDLE.
- Latency:
  - Normal end: out_valid rises 2 cycles after the first trigger_in=0 sample (ACTIVE->EMIT, then register load).
  - Truncated end: out_valid rises 2 cycles after the MAX_WIDTH-th sample.
- Handshake:
  - A record transfers on a cycle with out_valid & out_ready; out_valid drops the next cycle unless a new record loads in the same cycle.
  - Output fields are stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- enable=0: FSM synchronously forced to IDLE and any partial pulse discarded. No drop count is taken. The output register and handshake keep working, so a pending record can still drain.
- Counters saturate at 0xFFFF and clear only on reset.

Test Plan:
1. Basic pulse: HOLDOFF=4, baseline=100, trigger high 5 samples with x=100,150,300,200,120 → after a cycle with out_ready=1: out_peak=200, out_peak_pos=2, out_width=5, out_charge=370, out_truncated=0, out_ts = timestamp of the first sample, out_valid 2 cycles after trigger falls.
2. Equal peaks: amp sequence 50,80,80,10 → out_peak=80, out_peak_pos=1.
3. Truncation: MAX_WIDTH=8, trigger held high 20 cycles with amp=10 → out_width=8, out_charge=80, out_truncated=1. No second record until trigger falls, holdoff expires and a new rising edge arrives.
4. Holdoff: HOLDOFF=10, two 1-cycle triggers 3 cycles apart → one record, suppressed_count=1. The same two triggers 20 cycles apart → two records.
5. Backpressure: out_ready=0, three separated pulses → first record held stable, drop_count=2; raise out_ready → one transfer, out_valid=0.
6. Saturation and reset: baseline=-32768, x=32767 → amp=32767; CHARGE_W=16 with 3 samples → out_charge=32767. Assert reset_n low mid-pulse (asynchronous) → out_valid=0, counters 0 immediately; no record after release.
